// File: rtl/regfile_writeback.sv
// Register-file write-port controller: merges ALU and load results into one
// registered write per cycle, buffers loads in a FIFO, and tracks pending writes per register.
module regfile_writeback #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [DWIDTH-1:0]          alu_data_i,
    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [4:0]                 mem_rd_i,
    input  logic [DWIDTH-1:0]          mem_data_i,
    input  logic                       issue_valid_i,
    input  logic [4:0]                 issue_rd_i,
    output logic                       issue_ready_o,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    output logic                       rs1_busy_o,
    output logic                       rs2_busy_o,
    output logic [4:0]                 rd_o,
    output logic [DWIDTH-1:0]          datawb_o,
    output logic                       regwren_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [4:0]        r_fifo_rd   [DEPTH];
    logic [DWIDTH-1:0] r_fifo_data [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              r_wren_p1;
    logic [4:0]        r_rd_p1;
    logic [DWIDTH-1:0] r_data_p1;

    logic [1:0]        r_pend [32];

    logic              w_alu_win;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_inc;
    logic [31:0]       w_ret;

    // A dropped x0 ALU result does not claim the write port.
    assign w_alu_win     = alu_valid_i && (alu_rd_i != 5'd0);
    assign mem_ready_o   = (r_count < CW'(DEPTH)) && !rst;
    assign w_push        = mem_valid_i && mem_ready_o && (mem_rd_i != 5'd0);
    assign w_pop         = !w_alu_win && (r_count != '0);
    assign issue_ready_o = (r_pend[issue_rd_i] != 2'd3) && !rst;
    assign rs1_busy_o    = (r_pend[rs1_i] != 2'd0);
    assign rs2_busy_o    = (r_pend[rs2_i] != 2'd0);
    assign rd_o          = r_rd_p1;
    assign datawb_o      = r_data_p1;
    assign regwren_o     = r_wren_p1;
    assign fifo_count_o  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mem_rd_i;
            r_fifo_data[r_wptr] <= mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---- stage p1: registered RF write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren_p1 <= 1'b0;
            r_rd_p1   <= 5'd0;
            r_data_p1 <= '0;
        end else begin
            r_wren_p1 <= w_alu_win || w_pop;
            if (w_alu_win) begin
                r_rd_p1   <= alu_rd_i;
                r_data_p1 <= alu_data_i;
            end else if (w_pop) begin
                r_rd_p1   <= r_fifo_rd[r_rptr];
                r_data_p1 <= r_fifo_data[r_rptr];
            end
        end
    end

    always_comb begin
        w_inc = '0;
        w_ret = '0;
        if (issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0))
            w_inc[issue_rd_i] = 1'b1;
        if (r_wren_p1)
            w_ret[r_rd_p1] = 1'b1;
    end

    // Issue and retire on the same edge cancel; retire at zero is a no-op.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_pend[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_inc[i] && !w_ret[i])
                    r_pend[i] <= r_pend[i] + 2'd1;
                else if (w_ret[i] && !w_inc[i] && (r_pend[i] != 2'd0))
                    r_pend[i] <= r_pend[i] - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed stimulus, expected writes queued in a
// scoreboard and checked by a monitor on the falling edge.
module tb_regfile_writeback;
    localparam int DW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid_i;
    logic [4:0]    alu_rd_i;
    logic [DW-1:0] alu_data_i;
    logic          mem_valid_i;
    logic          mem_ready_o;
    logic [4:0]    mem_rd_i;
    logic [DW-1:0] mem_data_i;
    logic          issue_valid_i;
    logic [4:0]    issue_rd_i;
    logic          issue_ready_o;
    logic [4:0]    rs1_i;
    logic [4:0]    rs2_i;
    logic          rs1_busy_o;
    logic          rs2_busy_o;
    logic [4:0]    rd_o;
    logic [DW-1:0] datawb_o;
    logic          regwren_o;
    logic [2:0]    fifo_count_o;

    int n_total = 0;
    int n_pass  = 0;
    logic [36:0] exp_q[$];

    regfile_writeback #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid_i   = 1'b0; alu_rd_i   = 5'd0; alu_data_i = '0;
        mem_valid_i   = 1'b0; mem_rd_i   = 5'd0; mem_data_i = '0;
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        rs1_i = 5'd0; rs2_i = 5'd0;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    always @(negedge clk) begin
        if (regwren_o === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write", rd_o, datawb_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rd_o, datawb_o} === e) n_pass++;
                else $display("FAIL wb_order: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                              rd_o, datawb_o, e[36:32], e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        // reset
        cyc(); cyc();
        chk("rst_wren", {31'd0, regwren_o}, 32'd0);
        chk("rst_count", {29'd0, fifo_count_o}, 32'd0);
        chk("rst_busy", {31'd0, rs1_busy_o}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready_o}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready_o}, 32'd0);
        chk("rst_rd", {27'd0, rd_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_mem_ready", {31'd0, mem_ready_o}, 32'd1);
        chk("post_rst_issue_ready", {31'd0, issue_ready_o}, 32'd1);

        // single ALU write, one-cycle latency
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        expect_wb(5'd5, 32'hDEADBEEF);
        cyc(); idle();
        chk("alu_lat_wren", {31'd0, regwren_o}, 32'd1);
        chk("alu_lat_rd", {27'd0, rd_o}, 32'd5);
        chk("alu_lat_data", datawb_o, 32'hDEADBEEF);
        cyc();
        chk("alu_idle_wren", {31'd0, regwren_o}, 32'd0);
        chk("alu_idle_hold", datawb_o, 32'hDEADBEEF);

        // ALU and load in the same cycle
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h33;
        mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h44;
        expect_wb(5'd3, 32'h33); expect_wb(5'd4, 32'h44);
        cyc(); idle();
        chk("mix_n1_rd", {27'd0, rd_o}, 32'd3);
        chk("mix_n1_count", {29'd0, fifo_count_o}, 32'd1);
        cyc();
        chk("mix_n2_wren", {31'd0, regwren_o}, 32'd1);
        chk("mix_n2_rd", {27'd0, rd_o}, 32'd4);
        cyc();
        chk("mix_n3_wren", {31'd0, regwren_o}, 32'd0);

        // fill FIFO behind continuous ALU traffic
        for (int i = 0; i < 4; i++) begin
            alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h100 + i;
            mem_valid_i = 1'b1; mem_rd_i = 5'(8 + i); mem_data_i = 32'h80 + i;
            expect_wb(5'd1, 32'h100 + i);
            cyc();
        end
        chk("full_count", {29'd0, fifo_count_o}, 32'd4);
        chk("full_ready", {31'd0, mem_ready_o}, 32'd0);
        // offered load at full must be refused even though a pop occurs
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b1; mem_rd_i = 5'd20; mem_data_i = 32'h99;
        for (int i = 0; i < 4; i++) expect_wb(5'(8 + i), 32'h80 + i);
        cyc(); idle();
        chk("drain_count", {29'd0, fifo_count_o}, 32'd3);
        chk("drain_ready", {31'd0, mem_ready_o}, 32'd1);
        chk("drain_rd", {27'd0, rd_o}, 32'd8);
        cyc(); cyc(); cyc(); cyc();
        chk("drain_done_wren", {31'd0, regwren_o}, 32'd0);
        chk("drain_done_count", {29'd0, fifo_count_o}, 32'd0);

        // pending scoreboard on x7
        issue_valid_i = 1'b1; issue_rd_i = 5'd7; rs1_i = 5'd7; rs2_i = 5'd7;
        #1;
        chk("sb_ready0", {31'd0, issue_ready_o}, 32'd1);
        chk("sb_busy0", {31'd0, rs1_busy_o}, 32'd0);
        cyc();
        chk("sb_busy1", {31'd0, rs1_busy_o}, 32'd1);
        cyc();
        chk("sb_ready2", {31'd0, issue_ready_o}, 32'd1);
        cyc();
        chk("sb_sat_ready", {31'd0, issue_ready_o}, 32'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h71;
        expect_wb(5'd7, 32'h71);
        cyc();
        issue_valid_i = 1'b0;
        alu_data_i = 32'h72; expect_wb(5'd7, 32'h72);
        cyc();
        alu_data_i = 32'h73; expect_wb(5'd7, 32'h73);
        cyc();
        alu_valid_i = 1'b0;
        #1;
        chk("sb_busy_third_wb", {31'd0, rs2_busy_o}, 32'd1);
        cyc();
        chk("sb_busy_clear", {31'd0, rs1_busy_o}, 32'd0);
        chk("sb_ready_clear", {31'd0, issue_ready_o}, 32'd1);

        // x0 handling
        idle();
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h1;
        cyc(); idle();
        chk("x0_alu_wren", {31'd0, regwren_o}, 32'd0);
        issue_valid_i = 1'b1; issue_rd_i = 5'd0; rs1_i = 5'd0;
        cyc(); issue_valid_i = 1'b0;
        chk("x0_busy", {31'd0, rs1_busy_o}, 32'd0);

        // reset with loads queued
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h11;
        mem_valid_i = 1'b1; mem_rd_i = 5'd12; mem_data_i = 32'h12;
        expect_wb(5'd1, 32'h11);
        cyc();
        alu_data_i = 32'h22; mem_rd_i = 5'd13; mem_data_i = 32'h13;
        expect_wb(5'd1, 32'h22);
        cyc(); idle();
        rst = 1'b1;
        #1;
        chk("rst_mid_count_before", {29'd0, fifo_count_o}, 32'd2);
        cyc();
        rst = 1'b0;
        chk("rst_mid_count", {29'd0, fifo_count_o}, 32'd0);
        chk("rst_mid_wren", {31'd0, regwren_o}, 32'd0);
        cyc(); cyc(); cyc();
        chk("rst_mid_no_wb", {31'd0, regwren_o}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
